// File: rtl/usr_pkg.sv
// usr_pkg: shared definitions for the universal-shift-register sequencer.
//   - Mode codes driven onto the register's mode input.
//   - Sequencer FSM state encoding.
package usr_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_HOLD = 2'b00;
    localparam mode_t MODE_SHR  = 2'b01;
    localparam mode_t MODE_SHL  = 2'b10;
    localparam mode_t MODE_LOAD = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        LOAD  = 2'b01,
        SHIFT = 2'b10,
        DONE  = 2'b11
    } state_t;

endpackage

// File: rtl/usr_shift_sequencer_if.sv
// usr_shift_sequencer_if: command handshake between a client and the sequencer.
//   cmd_valid  client -> sequencer   command offered
//   cmd_ready  sequencer -> client   command can be accepted
//   cmd_dir    client -> sequencer   0 = shift right, 1 = shift left
//   cmd_len    client -> sequencer   number of shifts (0 = load only)
//   cmd_data   client -> sequencer   value to parallel-load
interface usr_shift_sequencer_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_dir;
    logic [CNT_W-1:0] cmd_len;
    logic [WIDTH-1:0] cmd_data;

    modport master (
        output cmd_valid, cmd_dir, cmd_len, cmd_data,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_dir, cmd_len, cmd_data,
        output cmd_ready
    );
endinterface

// File: rtl/usr_shift_counter.sv
// usr_shift_counter: loadable down-counter that tracks remaining shifts.
//   clk, rst  clock and synchronous active-high reset
//   load      load load_val (has priority over dec)
//   load_val  initial count
//   dec       decrement by one (saturates at zero)
//   last      count == 1: the current shift is the final one
//   zero      count == 0: nothing left to shift
module usr_shift_counter #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             last,
    output logic             zero
);
    logic [CNT_W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (dec && count != '0)
            count <= count - 1'b1;
    end

    assign last = (count == CNT_W'(1));
    assign zero = (count == '0);
endmodule

// File: rtl/usr_shift_sequencer.sv
// usr_shift_sequencer: accepts one transfer command per handshake, parallel
// loads the external universal shift register, issues a counted burst of
// shifts while streaming each exiting bit, then reports the register contents.
//   clk, rst    clock and synchronous active-high reset
//   cmd         command handshake (slave side)
//   ser_in      bit inserted on each shift
//   sr_mode     register mode (hold / shr / shl / load)
//   sr_pin      register parallel input, non-zero only in LOAD
//   sr_slin     register left-shift serial input
//   sr_srin     register right-shift serial input
//   sr_pout     register parallel output
//   ser_out     bit leaving the register this cycle, qualified by ser_valid
//   done        one-cycle completion pulse
//   result      register contents at completion, held until the next done
// Optional: define USR_SEQ_ABORT_EN to add input abort / output aborted,
// which cut a LOAD or SHIFT short and jump straight to DONE.
module usr_shift_sequencer
    import usr_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    usr_shift_sequencer_if.slave cmd,
    input  logic                 ser_in,
    output logic [1:0]           sr_mode,
    output logic [WIDTH-1:0]     sr_pin,
    output logic                 sr_slin,
    output logic                 sr_srin,
    input  logic [WIDTH-1:0]     sr_pout,
    output logic                 ser_out,
    output logic                 ser_valid,
    output logic                 done,
    output logic [WIDTH-1:0]     result
`ifdef USR_SEQ_ABORT_EN
    ,
    input  logic                 abort,
    output logic                 aborted
`endif
);
    state_t           state, state_nxt;
    logic             accept;
    logic             dir_q;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] result_q;
    logic [CNT_W-1:0] len_eff;
    logic             cnt_dec;
    logic             cnt_last;
    logic             cnt_zero;

    assign cmd.cmd_ready = (state == IDLE) && !rst;
    assign accept        = cmd.cmd_valid && cmd.cmd_ready;

    // Lengths beyond the register width saturate to a full serialize.
    assign len_eff = (cmd.cmd_len > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : cmd.cmd_len;

    usr_shift_counter #(.CNT_W(CNT_W)) u_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .load_val (len_eff),
        .dec      (cnt_dec),
        .last     (cnt_last),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            result_q <= '0;
        end else begin
            state <= state_nxt;
            if (state == DONE)
                result_q <= sr_pout;
        end
    end

    // NOTE: the command latch carries no reset; it is only observed after
    // being written on accept, and sr_pin is gated to zero outside LOAD.
    always_ff @(posedge clk) begin
        if (accept) begin
            dir_q  <= cmd.cmd_dir;
            data_q <= cmd.cmd_data;
        end
    end

    // NOTE: every output of this block is given a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        sr_mode   = MODE_HOLD;
        sr_pin    = '0;
        sr_slin   = 1'b0;
        sr_srin   = 1'b0;
        ser_out   = 1'b0;
        ser_valid = 1'b0;
        done      = 1'b0;
        cnt_dec   = 1'b0;
        case (state)
            IDLE: begin
                if (accept)
                    state_nxt = LOAD;
            end
            LOAD: begin
                sr_mode   = MODE_LOAD;
                sr_pin    = data_q;
                state_nxt = cnt_zero ? DONE : SHIFT;
            end
            SHIFT: begin
                sr_mode   = dir_q ? MODE_SHL : MODE_SHR;
                sr_slin   = ser_in;
                sr_srin   = ser_in;
                ser_out   = dir_q ? sr_pout[WIDTH-1] : sr_pout[0];
                ser_valid = 1'b1;
                cnt_dec   = 1'b1;
                if (cnt_last)
                    state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
`ifdef USR_SEQ_ABORT_EN
        // The aborted cycle still drives its own mode; only the successor changes.
        if (abort && (state == LOAD || state == SHIFT))
            state_nxt = DONE;
`endif
    end

    // During the DONE cycle the register already holds the final value.
    assign result = (state == DONE) ? sr_pout : result_q;

`ifdef USR_SEQ_ABORT_EN
    logic aborted_q;

    // An accepted abort always leads into DONE, so this flag is high exactly then.
    always_ff @(posedge clk) begin
        if (rst)
            aborted_q <= 1'b0;
        else
            aborted_q <= abort && (state == LOAD || state == SHIFT);
    end

    assign aborted = aborted_q;
`endif
endmodule
